// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin two-master arbiter and sequencer in front of a single-port ROM.
// Latency: ROM strobed 1 cycle after as_ is sampled; rdy_ 2 cycles after if the ROM answers at once.
// Backpressure: one access in flight; losers hold as_ low until granted; a silent ROM is aborted after TIMEOUT.
module rom_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_as_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_lock_,
  output logic              m0_grnt_,
  output logic              m0_rdy_,
  input  logic              m1_as_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_lock_,
  output logic              m1_grnt_,
  output logic              m1_rdy_,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              rom_cs_,
  output logic              rom_as_,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_rdy_,
  input  logic [DATA_W-1:0] rom_rd_data,
  output logic              timeout_err
);

  // The wait counter is 8 bits wide because TIMEOUT never exceeds 255.
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;       // 0 = m0, 1 = m1
  logic              last_q, last_d;         // master served most recently
  logic              lock_vld_q, lock_vld_d;
  logic              lock_id_q, lock_id_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic elig0, elig1, grant_vld, grant_id;
  logic done_ok, timed_out, finish;
  logic owner_lock_n, lock_as_n;

  // A held lock restricts eligibility to the lock owner; ties go to the master not served last.
  assign elig0     = !m0_as_ && (!lock_vld_q || (lock_id_q == 1'b0));
  assign elig1     = !m1_as_ && (!lock_vld_q || (lock_id_q == 1'b1));
  assign grant_vld = (state_q == S_IDLE) && (elig0 || elig1);
  assign grant_id  = (elig0 && elig1) ? ~last_q : elig1;

  // A ROM answer wins over a timeout that lands in the same cycle.
  assign done_ok      = (state_q == S_WAIT) && !rom_rdy_;
  assign timed_out    = (state_q == S_WAIT) && rom_rdy_ && (cnt_q == TMO);
  assign finish       = done_ok || timed_out;
  assign owner_lock_n = owner_q ? m1_lock_ : m0_lock_;
  assign lock_as_n    = lock_id_q ? m1_as_ : m0_as_;

  assign rom_addr    = addr_q;
  assign timeout_err = err_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> ACCESS on a grant, ACCESS -> WAIT always, WAIT -> IDLE on rdy or abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_vld) state_d = S_ACCESS;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   if (finish) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: grant held through ACCESS/WAIT, strobes only in ACCESS, rdy_ and data only on completion.
  always_comb begin
    m0_grnt_  = 1'b1;
    m1_grnt_  = 1'b1;
    m0_rdy_   = 1'b1;
    m1_rdy_   = 1'b1;
    rom_cs_   = 1'b1;
    rom_as_   = 1'b1;
    m_rd_data = '0;
    if (state_q != S_IDLE) begin
      if (owner_q) m1_grnt_ = 1'b0;
      else         m0_grnt_ = 1'b0;
    end
    if (state_q == S_ACCESS) begin
      rom_cs_ = 1'b0;
      rom_as_ = 1'b0;
    end
    if (finish) begin
      if (owner_q) m1_rdy_ = 1'b0;
      else         m0_rdy_ = 1'b0;
    end
    if (done_ok) m_rd_data = rom_rd_data;
  end

  // Datapath next state: owner/address capture, wait counter, round-robin pointer, lock and error flag.
  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (lock_vld_q && lock_as_n) lock_vld_d = 1'b0;
        if (grant_vld) begin
          owner_d = grant_id;
          addr_d  = grant_id ? m1_addr : m0_addr;
        end
      end
      S_ACCESS: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (finish) last_d = owner_q;
        if (done_ok && !owner_lock_n) begin
          lock_vld_d = 1'b1;
          lock_id_d  = owner_q;
        end
        if (timed_out) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; the pointer resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed scenarios plus randomized traffic for rom_arbiter.
// A ROM model answers strobes (fixed, random or never); a transaction-level round-robin model predicts grants.
// All checks sample at the falling edge; inputs change only after sampling.
module tb_rom_arbiter;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic          clk;
  logic          reset;
  logic          m0_as_, m0_lock_, m0_grnt_, m0_rdy_;
  logic          m1_as_, m1_lock_, m1_grnt_, m1_rdy_;
  logic [AW-1:0] m0_addr, m1_addr, rom_addr;
  logic [DW-1:0] m_rd_data, rom_rd_data;
  logic          rom_cs_, rom_as_, rom_rdy_, timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Snapshots taken at each falling edge.
  logic          s_g0, s_g1, s_r0, s_r1, s_cs, s_as, s_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;

  // ROM model state: mode 0 = never answers, 1 = answers next cycle, 2 = answers after 1..3 cycles.
  int            rom_mode;
  int            rom_cnt;
  bit            rom_stray;
  logic [AW-1:0] rom_lat_addr;

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_as_(m0_as_), .m0_addr(m0_addr), .m0_lock_(m0_lock_), .m0_grnt_(m0_grnt_), .m0_rdy_(m0_rdy_),
    .m1_as_(m1_as_), .m1_addr(m1_addr), .m1_lock_(m1_lock_), .m1_grnt_(m1_grnt_), .m1_rdy_(m1_rdy_),
    .m_rd_data(m_rd_data), .rom_cs_(rom_cs_), .rom_as_(rom_as_), .rom_addr(rom_addr),
    .rom_rdy_(rom_rdy_), .rom_rd_data(rom_rd_data), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] romval(input logic [AW-1:0] a);
    if (a == 11'h005) return 32'hDEADBEEF;
    return {a, 10'h155, a};
  endfunction

  // One clock: the ROM reacts just after the rising edge to the strobe seen in the previous cycle,
  // holding rdy_ low for one full cycle; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rom_rdy_) begin
      rom_rdy_    = 1'b1;
      rom_rd_data = $urandom;
    end
    if (!s_cs && !s_as) begin
      rom_lat_addr = s_addr;
      rom_cnt = (rom_mode == 0) ? 0 : (rom_mode == 1) ? 1 : int'($urandom_range(3, 1));
    end
    if (rom_cnt > 0) begin
      rom_cnt--;
      if (rom_cnt == 0) begin
        rom_rdy_    = 1'b0;
        rom_rd_data = romval(rom_lat_addr);
      end
    end else if (rom_stray) begin
      rom_rdy_    = 1'b0;
      rom_rd_data = $urandom;
    end
    @(negedge clk);
    cyc++;
    s_g0 = m0_grnt_; s_g1 = m1_grnt_; s_r0 = m0_rdy_; s_r1 = m1_rdy_;
    s_cs = rom_cs_;  s_as = rom_as_;  s_addr = rom_addr; s_data = m_rd_data; s_err = timeout_err;
  endtask

  task automatic wait_rdy(input int budget, output int n, output bit seen);
    seen = 0; n = 0;
    while (!seen && n < budget) begin
      tick(); n++;
      seen = (s_r0 === 1'b0) || (s_r1 === 1'b0);
    end
  endtask

  task automatic wait_strobe(input int budget, output int n, output bit seen);
    seen = 0; n = 0;
    while (!seen && n < budget) begin
      tick(); n++;
      seen = (s_as === 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_as_ = 1'b1; m1_as_ = 1'b1; m0_lock_ = 1'b1; m1_lock_ = 1'b1;
    rom_mode = 1; rom_cnt = 0; rom_stray = 0; rom_rdy_ = 1'b1;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({s_cs, s_as} !== 2'b11) begin failures++; $display("FAIL reset_strobes: got %b expected 11", {s_cs, s_as}); end
    checks++; if (s_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h expected 000", s_addr); end
    checks++; if ({s_g0, s_g1, s_r0, s_r1} !== 4'hF) begin failures++; $display("FAIL reset_grnt_rdy: got %b expected 1111", {s_g0, s_g1, s_r0, s_r1}); end
    checks++; if (s_data !== '0) begin failures++; $display("FAIL reset_data: got %h expected 0", s_data); end
    checks++; if (s_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", s_err); end
  endtask

  task automatic test_single();
    m0_addr = 11'h005; m0_as_ = 1'b0;
    tick();
    checks++; if (s_as !== 1'b0 || s_cs !== 1'b0 || s_addr !== 11'h005 || s_g0 !== 1'b0)
      begin failures++; $display("FAIL single_strobe: got as=%b cs=%b addr=%h g0=%b expected 0 0 005 0", s_as, s_cs, s_addr, s_g0); end
    tick();
    checks++; if (s_r0 !== 1'b0 || s_data !== 32'hDEADBEEF)
      begin failures++; $display("FAIL single_rdy: got rdy=%b data=%h expected 0 deadbeef", s_r0, s_data); end
    checks++; if (s_r1 !== 1'b1 || s_as !== 1'b1)
      begin failures++; $display("FAIL single_other: got m1_rdy=%b rom_as=%b expected 1 1", s_r1, s_as); end
    m0_as_ = 1'b1;
    tick();
    checks++; if (s_r0 !== 1'b1 || s_data !== '0 || s_g0 !== 1'b1)
      begin failures++; $display("FAIL single_after: got rdy=%b data=%h grnt=%b expected 1 0 1", s_r0, s_data, s_g0); end
  endtask

  task automatic test_contention();
    int gcyc[4];
    int gwho[4];
    int ng = 0;
    int lastwho = 0;
    do_reset();
    m0_addr = 11'h100; m1_addr = 11'h2AA;
    m0_as_ = 1'b0; m1_as_ = 1'b0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      tick();
      if (!s_r0 || !s_r1) begin
        checks++;
        if ({s_r1, s_r0} !== (lastwho == 1 ? 2'b01 : 2'b10) || s_data !== romval(lastwho == 1 ? m1_addr : m0_addr))
          begin failures++; $display("FAIL cont_rdy: got rdy1/0=%b data=%h for master %0d", {s_r1, s_r0}, s_data, lastwho); end
      end
      if (!s_as) begin
        gcyc[ng] = cyc;
        gwho[ng] = s_g0 ? 1 : 0;
        lastwho  = gwho[ng];
        checks++;
        if (s_addr !== (lastwho == 1 ? m1_addr : m0_addr))
          begin failures++; $display("FAIL cont_addr: got %h for master %0d", s_addr, lastwho); end
        ng++;
      end
    end
    checks++;
    if (ng != 4) begin failures++; $display("FAIL cont_count: got %0d grants expected 4", ng); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gwho[k] != (k % 2)) begin failures++; $display("FAIL cont_order: grant %0d got master %0d expected %0d", k, gwho[k], k % 2); end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (gcyc[k] - gcyc[k-1] != 3) begin failures++; $display("FAIL cont_spacing: got %0d cycles expected 3", gcyc[k] - gcyc[k-1]); end
      end
    end
    m0_as_ = 1'b1; m1_as_ = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_lock();
    int  n;
    bit  seen;
    do_reset();
    m0_addr = 11'h011; m0_as_ = 1'b0;
    wait_rdy(10, n, seen);
    checks++; if (!seen || s_r0 !== 1'b0) begin failures++; $display("FAIL lock_setup: got seen=%0d m0_rdy=%b expected 1 0", seen, s_r0); end
    m1_addr = 11'h022; m1_as_ = 1'b0; m1_lock_ = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_rdy(10, n, seen);
      checks++;
      if (!seen || s_r1 !== 1'b0 || s_r0 !== 1'b1 || s_data !== romval(11'h022))
        begin failures++; $display("FAIL lock_burst: serve %0d got rdy1/0=%b data=%h expected 01 %h", k, {s_r1, s_r0}, s_data, romval(11'h022)); end
    end
    m1_lock_ = 1'b1; m1_as_ = 1'b1;
    wait_strobe(10, n, seen);
    checks++;
    if (!seen || s_g0 !== 1'b0 || s_addr !== 11'h011)
      begin failures++; $display("FAIL lock_release: got seen=%0d g0=%b addr=%h expected 1 0 011", seen, s_g0, s_addr); end
    wait_rdy(10, n, seen);
    m0_as_ = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    rom_mode = 0;
    m0_addr = 11'h033; m0_as_ = 1'b0;
    wait_strobe(5, n, seen);
    checks++; if (!seen || s_err !== 1'b0) begin failures++; $display("FAIL to_start: got seen=%0d err=%b expected 1 0", seen, s_err); end
    wait_rdy(60, n, seen);
    checks++; if (!seen || n - 1 != TMO) begin failures++; $display("FAIL to_latency: got %0d cycles in WAIT expected %0d", n - 1, TMO); end
    checks++; if (s_r0 !== 1'b0 || s_r1 !== 1'b1 || s_data !== '0)
      begin failures++; $display("FAIL to_pulse: got rdy0=%b rdy1=%b data=%h expected 0 1 0", s_r0, s_r1, s_data); end
    m0_as_ = 1'b1; rom_mode = 1;
    tick();
    checks++; if (s_err !== 1'b1 || s_r0 !== 1'b1) begin failures++; $display("FAIL to_err: got err=%b rdy0=%b expected 1 1", s_err, s_r0); end
    m0_addr = 11'h044; m0_as_ = 1'b0;
    wait_rdy(10, n, seen);
    checks++; if (!seen || n != 2 || s_data !== romval(11'h044) || s_err !== 1'b1)
      begin failures++; $display("FAIL to_next: got n=%0d data=%h err=%b expected 2 %h 1", n, s_data, s_err, romval(11'h044)); end
    m0_as_ = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    rom_mode = 0;
    m0_addr = 11'h055; m0_as_ = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if ({m0_rdy_, m1_rdy_, m0_grnt_, m1_grnt_, rom_cs_, rom_as_} !== 6'h3F)
      begin failures++; $display("FAIL rstmid_ctrl: got %b expected 111111", {m0_rdy_, m1_rdy_, m0_grnt_, m1_grnt_, rom_cs_, rom_as_}); end
    checks++; if (rom_addr !== '0 || m_rd_data !== '0 || timeout_err !== 1'b0)
      begin failures++; $display("FAIL rstmid_data: got addr=%h data=%h err=%b expected 0 0 0", rom_addr, m_rd_data, timeout_err); end
    rom_cnt = 0; rom_rdy_ = 1'b1; rom_mode = 1;
    m1_addr = 11'h066; m1_as_ = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (s_r0 !== 1'b1 || s_r1 !== 1'b1 || s_as !== 1'b1)
        begin failures++; $display("FAIL rstmid_quiet: got rdy0=%b rdy1=%b as=%b expected 1 1 1", s_r0, s_r1, s_as); end
    end
    reset = 1'b1;
    wait_strobe(5, n, seen);
    checks++; if (!seen || s_g0 !== 1'b0 || s_addr !== 11'h055)
      begin failures++; $display("FAIL rstmid_tie: got seen=%0d g0=%b addr=%h expected 1 0 055", seen, s_g0, s_addr); end
    wait_rdy(10, n, seen);
    m0_as_ = 1'b1; m1_as_ = 1'b1;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_withdraw();
    int strobes = 0;
    int pulses  = 0;
    m0_addr = 11'h077; m0_as_ = 1'b0;
    tick();
    checks++; if (s_as !== 1'b0 || s_g0 !== 1'b0) begin failures++; $display("FAIL wd_grant: got as=%b g0=%b expected 0 0", s_as, s_g0); end
    m0_as_ = 1'b1;
    m0_addr = 11'h7FF;
    tick();
    checks++; if (s_r0 !== 1'b0 || s_data !== romval(11'h077))
      begin failures++; $display("FAIL wd_rdy: got rdy=%b data=%h expected 0 %h", s_r0, s_data, romval(11'h077)); end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!s_as) strobes++;
      if (!s_r0 || !s_r1) pulses++;
    end
    checks++; if (strobes != 0 || pulses != 0)
      begin failures++; $display("FAIL wd_quiet: got strobes=%0d pulses=%0d expected 0 0", strobes, pulses); end
  endtask

  task automatic test_stray();
    rom_stray = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (s_r0 !== 1'b1 || s_r1 !== 1'b1 || s_data !== '0 || s_as !== 1'b1)
        begin failures++; $display("FAIL stray: got rdy0=%b rdy1=%b data=%h as=%b expected 1 1 0 1", s_r0, s_r1, s_data, s_as); end
    end
    rom_stray = 0;
    tick(); tick();
  endtask

  // Random traffic against a transaction-level model: each master holds a request until served,
  // a grant goes to the only requester or, on a tie, to the master not served last.
  task automatic test_random();
    logic          p0, p1, pp0, pp1, last_m, busy, own;
    logic [AW-1:0] gaddr;
    int            gcyc_r = 0;
    int            served = 0;
    do_reset();
    rom_mode = 2;
    last_m = 1'b1; p0 = 1'b0; p1 = 1'b0; pp0 = 1'b0; pp1 = 1'b0; busy = 1'b0; own = 1'b0; gaddr = '0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (!s_as) begin
        checks++;
        if (!(pp0 || pp1) || busy) begin
          failures++; $display("FAIL rnd_spurious: got strobe with req=%b%b busy=%b", pp1, pp0, busy);
        end else begin
          own    = (pp0 && pp1) ? ~last_m : pp1;
          gaddr  = own ? m1_addr : m0_addr;
          busy   = 1'b1;
          gcyc_r = cyc;
          if (s_addr !== gaddr || {s_g1, s_g0} !== (own ? 2'b01 : 2'b10))
            begin failures++; $display("FAIL rnd_grant: got addr=%h g1/g0=%b expected %h master %0d", s_addr, {s_g1, s_g0}, gaddr, own); end
        end
      end
      checks++;
      if (!s_r0 || !s_r1) begin
        if (!busy || {s_r1, s_r0} !== (own ? 2'b01 : 2'b10) || s_data !== romval(gaddr))
          begin failures++; $display("FAIL rnd_rdy: got rdy1/0=%b data=%h expected master %0d data %h", {s_r1, s_r0}, s_data, own, romval(gaddr)); end
        last_m = own; busy = 1'b0; served++;
        if (own) p1 = 1'b0; else p0 = 1'b0;
      end else if (s_data !== '0 || (busy && cyc - gcyc_r > 6)) begin
        failures++; $display("FAIL rnd_idle: got data=%h busy_cycles=%0d expected 0 and <=6", s_data, cyc - gcyc_r);
        busy = 1'b0;
      end
      if (!p0 && i < 1400 && $urandom_range(2, 0) == 0) begin p0 = 1'b1; m0_addr = AW'($urandom); end
      if (!p1 && i < 1400 && $urandom_range(2, 0) == 0) begin p1 = 1'b1; m1_addr = AW'($urandom); end
      if (busy && $urandom_range(1, 0) == 1) begin
        if (own) m1_addr = AW'($urandom);
        else     m0_addr = AW'($urandom);
      end
      m0_as_ = ~p0; m1_as_ = ~p1;
      pp0 = p0; pp1 = p1;
    end
    checks++; if (p0 || p1 || busy || served < 100)
      begin failures++; $display("FAIL rnd_drain: got pending=%b%b busy=%b served=%0d expected 00 0 >=100", p1, p0, busy, served); end
  endtask

  initial begin
    reset = 1'b0;
    m0_as_ = 1'b1; m1_as_ = 1'b1; m0_lock_ = 1'b1; m1_lock_ = 1'b1;
    m0_addr = '0; m1_addr = '0;
    rom_rdy_ = 1'b1; rom_rd_data = '0; rom_mode = 1; rom_cnt = 0; rom_stray = 0; rom_lat_addr = '0;
    s_g0 = 1'b1; s_g1 = 1'b1; s_r0 = 1'b1; s_r1 = 1'b1; s_cs = 1'b1; s_as = 1'b1; s_err = 1'b0;
    s_addr = '0; s_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    test_stray();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Two-master arbiter and sequencer placed in front of the single-port ROM.
- The ROM samples cs_/as_/addr and returns rdy_ and rd_data one cycle later.
- Lets two requesters share the ROM: typically the instruction-fetch path (m0) and the bus/boot-copy path (m1).
- Grants one access at a time by round-robin, supports a lock for back-to-back bursts, and aborts accesses that never complete using a timeout.

Parameters:
- ADDR_W, 11: ROM word-address width.
- DATA_W, 32: word data width.
- TIMEOUT, 15: WAIT-state cycles before abort; legal range 2..255.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous reset, active low.
- m0_as_, input, 1: master 0 request/address strobe, active low.
- m0_addr, input, ADDR_W: master 0 address.
- m0_lock_, input, 1: master 0 keeps ownership after completion, active low.
- m0_grnt_, output, 1: master 0 currently owns the ROM, active low.
- m0_rdy_, output, 1: master 0 access complete, active low.
- m1_as_, m1_addr, m1_lock_, m1_grnt_, m1_rdy_: same as the m0 signals, for master 1.
- m_rd_data, output, DATA_W: read data shared by both masters; valid only with the owner's rdy_.
- rom_cs_, output, 1: ROM chip select, active low.
- rom_as_, output, 1: ROM address strobe, active low.
- rom_addr, output, ADDR_W: ROM address.
- rom_rdy_, input, 1: ROM ready, active low.
- rom_rd_data, input, DATA_W: ROM read data.
- timeout_err, output, 1: sticky flag, high after any abort; cleared only by reset.

Behaviour:
- Reset (async, reset=0) values:
  - rom_cs_=rom_as_=1, rom_addr=0.
  - m0/m1_grnt_=1, m0/m1_rdy_=1, m_rd_data=0, timeout_err=0.
  - state=IDLE, last-served pointer=1 (so m0 wins the first tie), lock owner=none, timeout counter=0.
- Reset asserted mid-transaction: the access is dropped silently and no rdy_ is issued.
- State IDLE:
  - Sample m0_as_/m1_as_ each cycle.
  - If a lock owner is held, only that master is eligible. The lock owner is cleared when its as_ is high in IDLE.
  - Otherwise, with one requester, grant it. With both requesting, grant the master not served last.
  - On a grant, register the winner's address into rom_addr, drive rom_cs_=rom_as_=0 and its grnt_=0 in the next cycle, and go to ACCESS.
- State ACCESS (one cycle):
  - ROM strobes are asserted for this cycle only.
  - Next cycle: rom_cs_=rom_as_=1; go to WAIT with the counter cleared.
- State WAIT:
  - When rom_rdy_=0: owner's m*_rdy_=0 for exactly this cycle; m_rd_data=rom_rd_data (combinational path).
  - In that cycle: update the last-served pointer, capture lock owner = owner if its lock_=0, deassert grnt_ next cycle, go to IDLE.
- Timeout: if the counter reaches TIMEOUT with rom_rdy_ still 1:
  - Owner's rdy_=0 for one cycle with m_rd_data=0.
  - timeout_err is set to 1.
  - Return to IDLE; the lock is not captured.
- The non-owner's rdy_ stays 1 at all times; m_rd_data=0 whenever no rdy_ is asserted.
- Latency: 2 cycles from the sampled as_ to rdy_. Throughput: one access every 3 cycles.
- Withdrawal: a master that raises as_ after it has been granted still receives the rdy_ pulse; the access is not cancelled.
- Stray rom_rdy_=0 in IDLE or ACCESS is ignored.
- Simultaneous new requests in the same cycle are resolved only by round-robin; there is no fixed priority except immediately after reset.
- Address changes on m*_addr after the grant have no effect, because the address is registered.

Test Plan:
- Single access: m0_as_=0, m0_addr=0x005, ROM returns 0xDEADBEEF -> rom_as_=0 with rom_addr=0x005 at cycle 1; m0_rdy_=0 and m_rd_data=0xDEADBEEF at cycle 2; m1_rdy_ stays 1.
- Contention: m0 and m1 request continuously from reset -> grants m0, m1, m0, m1, one grant every 3 cycles; each master's rdy_ returns its own address's data.
- Lock: m1 wins with m1_lock_=0 while m0 also requests -> m1 served 3 times consecutively; after m1_lock_=1 and m1_as_=1, m0 is granted next.
- Timeout: ROM model holds rom_rdy_=1 -> owner rdy_=0 exactly TIMEOUT cycles after entering WAIT (15 with the default), m_rd_data=0, timeout_err=1 and stays 1; the next access completes normally.
- Reset mid-operation: reset=0 during WAIT -> all outputs return to reset values immediately with no rdy_ pulse; after release, m0 wins the first tie.
- Withdrawal: m0 granted, then m0_as_=1 in ACCESS -> m0_rdy_ still pulses once in WAIT; nothing else is issued to the ROM.
